// File: rtl/i2c_seq_pkg.sv
// Shared register map, command/status bit positions, response codes and state encodings
// for the I2C transfer sequencer and its APB access engine.
package i2c_seq_pkg;

  localparam logic [7:0] REG_PRE    = 8'h00;
  localparam logic [7:0] REG_CTRL   = 8'h04;
  localparam logic [7:0] REG_TX     = 8'h08;
  localparam logic [7:0] REG_RX     = 8'h0C;
  localparam logic [7:0] REG_CMD    = 8'h10;
  localparam logic [7:0] REG_STATUS = 8'h14;

  localparam int CMD_STA = 7;
  localparam int CMD_STO = 6;
  localparam int CMD_RD  = 5;
  localparam int CMD_WR  = 4;
  localparam int CMD_ACK = 3;

  localparam int ST_RXACK = 7;
  localparam int ST_BUSY  = 6;
  localparam int ST_AL    = 5;
  localparam int ST_TIP   = 1;

  localparam logic [7:0] CTRL_EN = 8'h80;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_AL      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    INIT_PRE, INIT_CTRL, IDLE, WR_TX, WR_CMD, GAP,
    POLL, CHECK, STOP, STOP_POLL, RD_RX, RSP
  } seq_state_t;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_phase_t;

  function automatic logic [7:0] cmd_bits(input logic sta, input logic sto, input logic rd,
                                          input logic wr, input logic ack);
    logic [7:0] c;
    c = '0;
    c[CMD_STA] = sta;
    c[CMD_STO] = sto;
    c[CMD_RD]  = rd;
    c[CMD_WR]  = wr;
    c[CMD_ACK] = ack;
    return c;
  endfunction

  localparam logic [7:0] CMD_STOP = 8'h40;

  // Command for each byte stage; a read repeats START at stage 2 and NACK+STOP-reads at stage 3.
  function automatic logic [7:0] stage_cmd(input logic write, input logic [1:0] step);
    case (step)
      2'd0:    return cmd_bits(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      2'd1:    return cmd_bits(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      2'd2:    return write ? cmd_bits(1'b0, 1'b1, 1'b0, 1'b1, 1'b0)
                            : cmd_bits(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      default: return cmd_bits(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endcase
  endfunction

  function automatic logic [7:0] stage_tx(input logic write, input logic [1:0] step,
                                          input logic [6:0] dev, input logic [7:0] regaddr,
                                          input logic [7:0] wdata);
    case (step)
      2'd0:    return {dev, 1'b0};
      2'd1:    return regaddr;
      default: return write ? wdata : {dev, 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/i2c_seq_apb_master.sv
// Performs one APB access per start pulse; done pulses one cycle after the PREADY completion.
// Setup lasts one cycle; access phase stretches for as long as the slave holds PREADY low.
module i2c_seq_apb_master
  import i2c_seq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      write,
  input  logic [APB_ADDR_WIDTH-1:0] addr,
  input  logic [31:0]               wdata,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY
);

  apb_phase_t phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= APB_IDLE;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (phase)
        APB_IDLE: if (start) begin
          PADDR  <= addr;
          PWDATA <= wdata;
          PWRITE <= write;
          PSEL   <= 1'b1;
          phase  <= APB_SETUP;
        end
        APB_SETUP: begin
          PENABLE <= 1'b1;
          phase   <= APB_ACCESS;
        end
        APB_ACCESS: if (PREADY) begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          done    <= 1'b1;
          rdata   <= PRDATA;
          phase   <= APB_IDLE;
        end
        default: phase <= APB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_xfer_sequencer.sv
// Turns single-register I2C read/write requests into APB command sequences for an I2C core.
// Variable latency; req_ready only in IDLE, response held until rsp_ready.
module i2c_xfer_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter logic [15:0] PRESCALE       = 16'd99,
  parameter int          POLL_LIMIT     = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [6:0]                req_dev,
  input  logic [7:0]                req_reg,
  input  logic [7:0]                req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [7:0]                rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY
);

  localparam int PCW = $clog2(POLL_LIMIT + 1);

  seq_state_t     state;
  logic [1:0]     step;
  logic [PCW-1:0] poll_cnt;
  logic           pending;
  logic           apb_start;
  logic           apb_done;
  logic [31:0]    apb_rdata;
  logic           lat_write;
  logic [6:0]     lat_dev;
  logic [7:0]     lat_reg;
  logic [7:0]     lat_wdata;

  logic                      acc_need;
  logic                      acc_write;
  logic [7:0]                acc_off;
  logic [31:0]               acc_wdata;
  logic [7:0]                status;
  logic                      last_step;
  logic                      poll_last;
  logic                      unused_rdata;

  assign status       = apb_rdata[7:0];
  assign unused_rdata = ^apb_rdata[31:8];
  assign last_step    = lat_write ? (step == 2'd2) : (step == 2'd3);
  assign poll_last    = (poll_cnt == PCW'(POLL_LIMIT - 1));

  always_comb begin
    acc_need  = 1'b1;
    acc_write = 1'b1;
    acc_off   = REG_CMD;
    acc_wdata = '0;
    case (state)
      INIT_PRE: begin
        acc_off   = REG_PRE;
        acc_wdata = {16'h0000, PRESCALE};
      end
      INIT_CTRL: begin
        acc_off   = REG_CTRL;
        acc_wdata = {24'h0, CTRL_EN};
      end
      WR_TX: begin
        acc_off   = REG_TX;
        acc_wdata = {24'h0, stage_tx(lat_write, step, lat_dev, lat_reg, lat_wdata)};
      end
      WR_CMD:  acc_wdata = {24'h0, stage_cmd(lat_write, step)};
      STOP:    acc_wdata = {24'h0, CMD_STOP};
      POLL, STOP_POLL: begin
        acc_write = 1'b0;
        acc_off   = REG_STATUS;
      end
      RD_RX: begin
        acc_write = 1'b0;
        acc_off   = REG_RX;
      end
      default: acc_need = 1'b0;
    endcase
  end

  i2c_seq_apb_master #(.APB_ADDR_WIDTH(APB_ADDR_WIDTH)) u_apb (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .start   (apb_start),
    .write   (acc_write),
    .addr    (APB_ADDR_WIDTH'(acc_off)),
    .wdata   (acc_wdata),
    .done    (apb_done),
    .rdata   (apb_rdata),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  // Every access state launches exactly one APB access and advances only on its done pulse.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= INIT_PRE;
      step      <= 2'd0;
      poll_cnt  <= '0;
      pending   <= 1'b0;
      apb_start <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= ERR_OK;
      lat_write <= 1'b0;
      lat_dev   <= 7'h00;
      lat_reg   <= 8'h00;
      lat_wdata <= 8'h00;
    end else begin
      apb_start <= 1'b0;
      if (acc_need && !pending) begin
        apb_start <= 1'b1;
        pending   <= 1'b1;
      end
      if (apb_done) pending <= 1'b0;

      case (state)
        INIT_PRE:  if (apb_done) state <= INIT_CTRL;
        INIT_CTRL: if (apb_done) begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        IDLE: if (req_valid && req_ready) begin
          lat_write <= req_write;
          lat_dev   <= req_dev;
          lat_reg   <= req_reg;
          lat_wdata <= req_wdata;
          req_ready <= 1'b0;
          step      <= 2'd0;
          rsp_rdata <= 8'h00;
          rsp_err   <= ERR_OK;
          state     <= WR_TX;
        end
        WR_TX:  if (apb_done) state <= WR_CMD;
        WR_CMD: if (apb_done) state <= GAP;
        GAP: begin
          poll_cnt <= '0;
          state    <= POLL;
        end
        POLL: if (apb_done) begin
          poll_cnt <= poll_cnt + 1'b1;
          if (!status[ST_TIP]) begin
            state <= CHECK;
          end else if (poll_last) begin
            rsp_err <= ERR_TIMEOUT;
            state   <= STOP;
          end
        end
        CHECK: begin
          if (status[ST_AL]) begin
            rsp_err   <= ERR_AL;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else if (status[ST_RXACK] && !(!lat_write && step == 2'd3)) begin
            rsp_err <= ERR_NACK;
            state   <= STOP;
          end else if (last_step) begin
            if (lat_write) begin
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else begin
              state <= RD_RX;
            end
          end else begin
            step  <= step + 2'd1;
            state <= (!lat_write && step == 2'd2) ? WR_CMD : WR_TX;
          end
        end
        STOP: if (apb_done) begin
          poll_cnt <= '0;
          if (rsp_err == ERR_TIMEOUT) begin
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            state <= STOP_POLL;
          end
        end
        // Bounded like the main wait so a stuck bus still produces a response.
        STOP_POLL: if (apb_done) begin
          poll_cnt <= poll_cnt + 1'b1;
          if (!status[ST_BUSY] || poll_last) begin
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_RX: if (apb_done) begin
          rsp_rdata <= apb_rdata[7:0];
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT_PRE;
      endcase
    end
  end

endmodule

// File: doc/i2c_xfer_sequencer.md
I2C_XFER_SEQUENCER -- requirements
Module: i2c_xfer_sequencer

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter PRESCALE, default 16'd99, value written to the I2C prescaler register at init.
REQ-003 SHALL have parameter POLL_LIMIT, default 1024, maximum status reads per wait before timeout.
REQ-004 SHALL have ports, one per line:
- HCLK  in  1  clock; one clock, all logic on its rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  sequencer accepts request.
- req_write  in  1  1 = register write, 0 = register read.
- req_dev  in  7  I2C device address.
- req_reg  in  8  device register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  8  read data, 0 for writes.
- rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address to I2C peripheral.
- PWDATA  out  32  APB write data.
- PWRITE, PSEL, PENABLE  out  1 each  APB controls.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.

Function
REQ-005 SHALL use peripheral offsets PRE 0x00, CTRL 0x04, TX 0x08, RX 0x0C, CMD 0x10, STATUS 0x14; CMD bits STA7 STO6 RD5 WR4 ACK3; STATUS bits RXACK7 BUSY6 AL5 TIP1.
REQ-006 SHALL perform each APB access as setup (PSEL=1, PENABLE=0) for one cycle, then access (PSEL=1, PENABLE=1) until PREADY=1, sampling PRDATA on that cycle; PSEL=0 between accesses.
REQ-007 SHALL, after reset, write PRE=PRESCALE then CTRL=0x80 before entering IDLE.
REQ-008 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready and its fields are latched.
REQ-009 Write sequence: TX=req_dev<<1, CMD=0x90, wait; TX=req_reg, CMD=0x10, wait; TX=req_wdata, CMD=0x50, wait.
REQ-010 Read sequence: TX=req_dev<<1, CMD=0x90, wait; TX=req_reg, CMD=0x10, wait; TX=(req_dev<<1)|1, CMD=0x90, wait; CMD=0x68, wait; read RX into rsp_rdata.
REQ-011 "Wait" SHALL insert one idle cycle after the CMD write, then read STATUS repeatedly until TIP=0.
REQ-012 After each wait: AL=1 -> rsp_err=10, no further APB writes; else RXACK=1 on an address/TX byte -> issue CMD=0x40, poll until BUSY=0, rsp_err=01; RXACK ignored after the final read byte.
REQ-013 If a wait reaches POLL_LIMIT status reads, SHALL write CMD=0x40 and respond rsp_err=11 without further polling.
REQ-014 AL SHALL take priority over RXACK when both are set.
REQ-015 SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready=1, then return to IDLE the following cycle.
REQ-016 States: INIT_PRE, INIT_CTRL, IDLE, WR_TX, WR_CMD, GAP, POLL, CHECK, STOP, STOP_POLL, RD_RX, RSP; a step counter (0-3) selects the byte stage.

Reset
REQ-017 On HRESETn=0 at a clock edge: state=INIT_PRE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters 0, including mid-transfer; init then repeats.

Structure
REQ-018 Register offsets, CMD/STATUS bit positions, rsp_err codes and the state enum SHALL live in shared package i2c_seq_pkg.
REQ-019 SHALL instantiate one sub-module i2c_seq_apb_master (single APB access, start/done handshake, read data out).

Verification
REQ-020 Reset, PREADY=1 -> first accesses: write 0x00=0x63, write 0x04=0x80, then req_ready=1.
REQ-021 Write dev=0x50 reg=0x12 data=0xA5, slave ACKs all -> TX writes 0xA0,0x12,0xA5, CMDs 0x90,0x10,0x50, rsp_err=00.
REQ-022 Read dev=0x50 reg=0x34, slave returns 0x5A -> TX 0xA0,0x34,0xA1, CMDs 0x90,0x10,0x90,0x68, rsp_rdata=0x5A, rsp_err=00.
REQ-023 Absent device (RXACK=1 after address) -> CMD=0x40 written, rsp_err=01, no register byte sent.
REQ-024 Status model holds TIP=1 forever, POLL_LIMIT=8 -> exactly 8 STATUS reads, CMD=0x40, rsp_err=11; PREADY low 3 cycles per access stretches timing only.
REQ-025 HRESETn low mid-read, then high -> PSEL=0, rsp_valid=0, init writes repeat, next request completes normally.
